// File: rtl/spinner_pkg.sv
// rtl/spinner_pkg.sv - shared types and helpers for the multi-channel spinner
package spinner_pkg;

  localparam int SPIN_IN_W    = 9;
  localparam int SPIN_TOG_BIT = 8;

  typedef logic signed [7:0] spin_delta_t;

  // Accumulator width: integer angle bits plus sub-step fraction bits
  function automatic int acc_w(input int out_w, input int frac_w);
    return out_w + frac_w;
  endfunction

endpackage

// File: rtl/spinner_ch.sv
// rtl/spinner_ch.sv - one spinner channel: digital stepping, analog deltas, wrap/clamp
module spinner_ch
  import spinner_pkg::*;
#(
  parameter int OUT_W    = 4,
  parameter int FRAC_W   = 2,
  parameter int SLOW_DIV = 8,
  parameter int FAST_DIV = 2,
  parameter int INIT     = 0
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 clamp,
  input  logic                 se,
  input  logic                 fast,
  input  logic                 plus,
  input  logic                 minus,
  input  logic [SPIN_IN_W-1:0] spin_in,
  output logic [OUT_W-1:0]     spin_out,
  output logic                 moved
);

  localparam int A     = acc_w(OUT_W, FRAC_W);
  localparam int SW    = A + 10;
  localparam int CNT_W = $clog2(SLOW_DIV) + 1;

  localparam logic signed [SW-1:0] STEP     = SW'(2 ** FRAC_W);
  localparam logic signed [SW-1:0] MAXV     = SW'((2 ** A) - 1);
  localparam logic [A-1:0]         ACC_INIT = A'(INIT * (2 ** FRAC_W));
  localparam logic [CNT_W-1:0]     SLOW_RLD = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0]     FAST_RLD = CNT_W'(FAST_DIV - 1);

  logic [A-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tog_q, tog_d;
  logic             arm_q, arm_d;
  logic             moved_q, moved_d;

  logic signed [SW-1:0] dig, ana, sum;
  spin_delta_t          delta;

  // Digital rate divider: first held strobe steps at once, then every DIV strobes
  always_comb begin
    cnt_d = cnt_q;
    dig   = '0;
    if (se) begin
      if (plus == minus) begin
        cnt_d = '0;
      end else if (cnt_q == '0) begin
        dig   = plus ? STEP : -STEP;
        cnt_d = fast ? FAST_RLD : SLOW_RLD;
      end else if (fast && (cnt_q > FAST_RLD)) begin
        cnt_d = FAST_RLD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Analog event detect: the first cycle out of reset only arms the toggle tracker
  always_comb begin
    tog_d = tog_q;
    arm_d = arm_q;
    ana   = '0;
    delta = spin_in[7:0];
    if (!arm_q) begin
      arm_d = 1'b1;
      tog_d = spin_in[SPIN_TOG_BIT];
    end else if (spin_in[SPIN_TOG_BIT] != tog_q) begin
      ana   = SW'(delta);
      tog_d = spin_in[SPIN_TOG_BIT];
    end
  end

  // Sum both contributions wide and signed, then wrap or saturate into the accumulator
  always_comb begin
    sum = $signed({10'b0, acc_q}) + dig + ana;
    if (clamp) begin
      if (sum[SW-1])       acc_d = '0;
      else if (sum > MAXV) acc_d = '1;
      else                 acc_d = sum[A-1:0];
    end else begin
      acc_d = sum[A-1:0];
    end
    moved_d = (acc_d[A-1:FRAC_W] != acc_q[A-1:FRAC_W]);
  end

  // Channel state registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= ACC_INIT;
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      arm_q   <= 1'b0;
      moved_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      arm_q   <= arm_d;
      moved_q <= moved_d;
    end
  end

  assign spin_out = acc_q[A-1:FRAC_W];
  assign moved    = moved_q;

endmodule

// File: rtl/spinner_mc.sv
// rtl/spinner_mc.sv - multi-channel spinner top: shared strobe edge detect plus channels
module spinner_mc
  import spinner_pkg::*;
#(
  parameter int CH       = 2,
  parameter int OUT_W    = 4,
  parameter int FRAC_W   = 2,
  parameter int SLOW_DIV = 8,
  parameter int FAST_DIV = 2,
  parameter int INIT     = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    clamp,
  input  logic                    strobe,
  input  logic [CH-1:0]           fast,
  input  logic [CH-1:0]           plus,
  input  logic [CH-1:0]           minus,
  input  logic [CH*SPIN_IN_W-1:0] spin_in,
  output logic [CH*OUT_W-1:0]     spin_out,
  output logic [CH-1:0]           moved
);

  logic strobe_d_q, strobe_d_d;
  logic se;

  // Delay strobe by one cycle so a held level counts only once
  always_comb begin
    strobe_d_d = strobe;
    se         = strobe & ~strobe_d_q;
  end

  // Strobe history register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) strobe_d_q <= 1'b0;
    else          strobe_d_q <= strobe_d_d;
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    spinner_ch #(
      .OUT_W   (OUT_W),
      .FRAC_W  (FRAC_W),
      .SLOW_DIV(SLOW_DIV),
      .FAST_DIV(FAST_DIV),
      .INIT    (INIT)
    ) u_ch (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clamp   (clamp),
      .se      (se),
      .fast    (fast[k]),
      .plus    (plus[k]),
      .minus   (minus[k]),
      .spin_in (spin_in[k*SPIN_IN_W +: SPIN_IN_W]),
      .spin_out(spin_out[k*OUT_W +: OUT_W]),
      .moved   (moved[k])
    );
  end

endmodule

// File: tb/tb_spinner_mc.sv
// tb/tb_spinner_mc.sv - directed self-checking bench for spinner_mc
module tb_spinner_mc;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        clamp   = 1'b0;
  logic        strobe  = 1'b0;
  logic [1:0]  fast    = '0;
  logic [1:0]  plus    = '0;
  logic [1:0]  minus   = '0;
  logic [17:0] spin_in = '0;
  logic [7:0]  spin_out;
  logic [1:0]  moved;

  logic [1:0]  tg = '0;
  int          n_chk = 0;
  int          n_err = 0;
  int          mv_cnt [2];
  int          base0, base1;

  spinner_mc dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clamp   (clamp),
    .strobe  (strobe),
    .fast    (fast),
    .plus    (plus),
    .minus   (minus),
    .spin_in (spin_in),
    .spin_out(spin_out),
    .moved   (moved)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    mv_cnt[0] = 0;
    mv_cnt[1] = 0;
  end

  always @(negedge clk_sys) begin
    if (moved[0]) mv_cnt[0] = mv_cnt[0] + 1;
    if (moved[1]) mv_cnt[1] = mv_cnt[1] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out(input int ch);
    return 32'(spin_out[ch*4 +: 4]);
  endfunction

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic strobe_pulse();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
  endtask

  task automatic toggle(input int ch, input logic [7:0] d);
    tg[ch] = ~tg[ch];
    spin_in[ch*9 +: 9] = {tg[ch], d};
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    // 1. reset with toggling inputs, then release with toggle bits high
    tick();
    toggle(0, 8'h05);
    toggle(1, 8'h7F);
    toggle(0, 8'h10);
    chk("rst_out", 32'(spin_out), 0);
    chk("rst_moved", 32'(moved), 0);
    tg = 2'b11;
    spin_in = {1'b1, 8'h22, 1'b1, 8'h33};
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("arm_out", 32'(spin_out), 0);
    chk("arm_moved_cnt", 32'(mv_cnt[0] + mv_cnt[1]), 0);

    // 2. slow digital on ch0
    base0 = mv_cnt[0];
    base1 = mv_cnt[1];
    plus[0] = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      strobe_pulse();
      if (i == 1) chk("slow_first", out(0), 1);
      if (i == 8) chk("slow_s8", out(0), 1);
    end
    chk("slow_out0", out(0), 3);
    chk("slow_moved0", 32'(mv_cnt[0] - base0), 3);
    chk("slow_out1", out(1), 0);
    chk("slow_moved1", 32'(mv_cnt[1] - base1), 0);
    plus[0] = 1'b0;
    strobe_pulse();

    // 3. fast minus on ch1 wraps below zero
    base1 = mv_cnt[1];
    fast[1]  = 1'b1;
    minus[1] = 1'b1;
    strobe_pulse();
    chk("fast_s1", out(1), 15);
    strobe_pulse();
    chk("fast_s2", out(1), 15);
    strobe_pulse();
    strobe_pulse();
    chk("fast_s4", out(1), 14);
    chk("fast_moved1", 32'(mv_cnt[1] - base1), 2);
    minus[1] = 1'b0;
    fast[1]  = 1'b0;
    strobe_pulse();

    // 4. analog fractional accumulation (fresh reset)
    do_reset();
    chk("rst2_out", 32'(spin_out), 0);
    toggle(0, 8'd6);
    chk("ana_p6_out", out(0), 1);
    chk("ana_p6_moved", 32'(moved[0]), 1);
    tick();
    chk("ana_moved_1cyc", 32'(moved[0]), 0);
    toggle(0, 8'd2);
    chk("ana_p2_out", out(0), 2);
    chk("ana_p2_moved", 32'(moved[0]), 1);
    toggle(0, 8'hF7);
    chk("ana_wrap_out", out(0), 15);
    chk("ana_ch1", out(1), 0);

    // 5. clamp mode
    clamp = 1'b1;
    toggle(0, 8'hFD);
    chk("clp_60_out", out(0), 15);
    chk("clp_60_moved", 32'(moved[0]), 0);
    toggle(0, 8'd10);
    chk("clp_hi_out", out(0), 15);
    chk("clp_hi_moved", 32'(moved[0]), 0);
    plus[0] = 1'b1;
    strobe_pulse();
    chk("clp_plus_out", out(0), 15);
    toggle(0, 8'h80);
    chk("clp_lo_out", out(0), 0);
    chk("clp_lo_moved", 32'(moved[0]), 1);
    plus[0] = 1'b0;
    strobe_pulse();
    clamp = 1'b0;

    // 6. simultaneous events
    plus[0]  = 1'b1;
    minus[0] = 1'b1;
    for (int i = 0; i < 3; i++) strobe_pulse();
    chk("both_out", out(0), 0);
    minus[0] = 1'b0;
    strobe_pulse();
    chk("both_cnt0_step", out(0), 1);
    plus[0] = 1'b0;
    strobe_pulse();
    tg[0] = ~tg[0];
    spin_in[8:0] = {tg[0], 8'd4};
    plus[0] = 1'b1;
    strobe  = 1'b1;
    tick();
    chk("sim_out", out(0), 3);
    chk("sim_moved", 32'(moved[0]), 1);
    strobe  = 1'b0;
    plus[0] = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
